// File: rtl/discus_loader_pkg.sv
// Shared types and constants for the discus snoop-port loader.
package discus_loader_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned LEN_BITS = 6;
  localparam int unsigned CNT_W    = LEN_BITS + 1;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRMEM = 2'b01,
    OP_WRPRG = 2'b10,
    OP_RDMEM = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    CMD   = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    ROUT  = 3'd5
  } state_e;

  // Command byte layout: opcode in the top two bits, burst length minus one below.
  typedef struct packed {
    op_e                 op;
    logic [LEN_BITS-1:0] len_m1;
  } cmd_t;

  // Burst length 1..64 from the encoded length field.
  function automatic logic [CNT_W-1:0] burst_len(input logic [LEN_BITS-1:0] len_m1);
    return CNT_W'(len_m1) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/discus_loader_if.sv
// Host byte stream, readback stream and discus snoop port bundled together.
interface discus_loader_if;
  import discus_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] snoopa;
  logic [BYTE_W-1:0] snoopd;
  logic              snoopm;
  logic              snoopp;
  logic [BYTE_W-1:0] snoopq;

  // Loader side: consumes host bytes, produces readback and snoop traffic.
  modport slave (
    input  in_data, in_valid, out_ready, snoopq,
    output in_ready, out_data, out_valid, snoopa, snoopd, snoopm, snoopp
  );

  // Environment side: host link plus the discus memories.
  modport master (
    output in_data, in_valid, out_ready, snoopq,
    input  in_ready, out_data, out_valid, snoopa, snoopd, snoopm, snoopp
  );

endinterface

// File: rtl/discus_loader_wdog.sv
// Idle-cycle watchdog: counts cycles without host input, flags expiry.
module discus_loader_wdog #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a state change always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT-th consecutive idle cycle.
  assign expire_o = inc_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/discus_loader.sv
// Host command sequencer driving the discus snoop port for burst load and dump.
module discus_loader
  import discus_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  discus_loader_if.slave   bus,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [BYTE_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  snoopa_q, snoopa_d;
  logic [BYTE_W-1:0]  snoopd_q, snoopd_d;
  logic               snoopm_q, snoopm_d;
  logic               snoopp_q, snoopp_d;
  logic [BYTE_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;

  cmd_t               cmd_c;
  logic               in_ready_c;
  logic               accept_c;
  logic               last_c;
  logic               wdog_inc_c;
  logic               wdog_clr_c;
  logic               expire_c;

  assign cmd_c      = cmd_t'(bus.in_data);
  assign in_ready_c = rst_n && ((state_q == CMD) || (state_q == ADDR) || (state_q == WDATA));
  assign accept_c   = bus.in_valid && in_ready_c;
  assign last_c     = (cnt_q == CNT_W'(1));

  // Watchdog only runs while a command is waiting on host bytes.
  assign wdog_inc_c = ((state_q == ADDR) || (state_q == WDATA)) && !bus.in_valid;
  assign wdog_clr_c = accept_c || (state_d != state_q);

  discus_loader_wdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (wdog_inc_c),
    .clr_i    (wdog_clr_c),
    .expire_o (expire_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CMD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CMD: begin
        if (accept_c && (cmd_c.op != OP_NOP)) state_d = ADDR;
      end
      ADDR: begin
        if (expire_c) begin
          state_d = CMD;
        end else if (accept_c) begin
          if (op_q == OP_RDMEM) state_d = RADDR;
          else                  state_d = WDATA;
        end
      end
      WDATA: begin
        if (expire_c || (accept_c && last_c)) state_d = CMD;
      end
      RADDR: state_d = RDATA;
      RDATA: state_d = ROUT;
      ROUT: begin
        if (bus.out_ready) begin
          if (last_c) state_d = CMD;
          else        state_d = RADDR;
        end
      end
      default: state_d = CMD;
    endcase
  end

  // Datapath and output next values; strobes default low every cycle.
  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    snoopa_d    = snoopa_q;
    snoopd_d    = snoopd_q;
    snoopm_d    = 1'b0;
    snoopp_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      CMD: begin
        if (accept_c) begin
          op_d  = cmd_c.op;
          cnt_d = burst_len(cmd_c.len_m1);
        end
      end
      ADDR: begin
        if (accept_c) addr_d = bus.in_data;
      end
      WDATA: begin
        if (accept_c) begin
          snoopa_d = addr_q;
          snoopd_d = bus.in_data;
          snoopm_d = (op_q == OP_WRMEM);
          snoopp_d = (op_q == OP_WRPRG);
          addr_d   = addr_q + BYTE_W'(1);
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      RADDR: snoopa_d = addr_q;
      RDATA: begin
        out_data_d  = bus.snoopq;
        out_valid_d = 1'b1;
      end
      ROUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + BYTE_W'(1);
          cnt_d       = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    // An abort in the same cycle as a clear leaves the flag set.
    if (expire_c)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_NOP;
      addr_q      <= '0;
      cnt_q       <= '0;
      snoopa_q    <= '0;
      snoopd_q    <= '0;
      snoopm_q    <= 1'b0;
      snoopp_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      snoopa_q    <= snoopa_d;
      snoopd_q    <= snoopd_d;
      snoopm_q    <= snoopm_d;
      snoopp_q    <= snoopp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.snoopa    = snoopa_q;
  assign bus.snoopd    = snoopd_q;
  assign bus.snoopm    = snoopm_q;
  assign bus.snoopp    = snoopp_q;
  assign busy          = (state_q != CMD);
  assign err           = err_q;

endmodule

// File: tb/tb_discus_loader.sv
// Bench for discus_loader: directed scenarios plus random bursts against a memory model.
module tb_discus_loader;

  localparam int unsigned TIMEOUT = 4096;
  localparam int unsigned TO_W    = 13;

  typedef struct {
    logic       prg;
    logic [7:0] a;
    logic [7:0] d;
    logic       busy;
    int         cyc;
  } wev_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic err_clr = 1'b0;
  logic busy;
  logic err;

  discus_loader_if bus ();

  discus_loader #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  // Discus memories (device model) and the bench's own expected contents.
  logic [7:0] dmem    [256] = '{default: 8'h00};
  logic [7:0] pmem    [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] ref_prg [256] = '{default: 8'h00};

  wev_t       wlog [$];
  logic [7:0] rlog [$];
  logic [7:0] wdata_q [$];
  int         cyc      = 0;
  int         both_cnt = 0;
  int         n_checks = 0;
  int         n_pass   = 0;

  assign bus.snoopq = dmem[bus.snoopa];

  always @(posedge clk) cyc <= cyc + 1;

  // Discus applies snoop writes on the clock edge.
  always @(posedge clk) begin
    if (bus.snoopm) dmem[bus.snoopa] <= bus.snoopd;
    if (bus.snoopp) pmem[bus.snoopa] <= bus.snoopd;
  end

  // Log strobes and readback handshakes mid-cycle.
  always @(negedge clk) begin
    if (bus.snoopm || bus.snoopp)
      wlog.push_back('{prg: bus.snoopp, a: bus.snoopa, d: bus.snoopd, busy: busy, cyc: cyc});
    if (bus.snoopm && bus.snoopp) both_cnt++;
    if (bus.out_valid && bus.out_ready) rlog.push_back(bus.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic wev_t ev_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return '{prg: 1'b1, a: 8'h00, d: 8'h00, busy: 1'b1, cyc: -100};
  endfunction

  function automatic logic [7:0] rd_at(input int i);
    if (i < rlog.size()) return rlog[i];
    return 8'hxx;
  endfunction

  task automatic send(input logic [7:0] b);
    bit done = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int w = 0; w < 64 && !done; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    check($sformatf("send_accept_%02h", b), 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    for (int w = 0; w < bound && busy; w++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write burst from wdata_q; expectation is address+i (mod 256) with the queued bytes.
  task automatic wr_burst(input logic prg, input logic [7:0] addr, input int maxgap, input string lbl);
    int n    = wdata_q.size();
    int base = wlog.size();
    wev_t ev;
    send({(prg ? 2'b10 : 2'b01), 6'(n - 1)});
    send(addr);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk);
        #1;
      end
      send(wdata_q[i]);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({lbl, "_count"}, 32'(wlog.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [7:0] ea = addr + 8'(i);
      ev = ev_at(base + i);
      check($sformatf("%s_ev%0d", lbl, i), {15'd0, ev.prg, ev.a, ev.d}, {15'd0, prg, ea, wdata_q[i]});
      if (prg) ref_prg[ea] = wdata_q[i];
      else     ref_mem[ea] = wdata_q[i];
    end
    check({lbl, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Read burst; expected bytes come from the bench's reference memory.
  task automatic rd_burst(input logic [7:0] addr, input int n, input bit rnd, input string lbl);
    int base = rlog.size();
    bus.out_ready = 1'b1;
    send({2'b11, 6'(n - 1)});
    send(addr);
    for (int w = 0; w < 2000 && busy; w++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    check({lbl, "_done"}, 32'(busy), 32'd0);
    check({lbl, "_count"}, 32'(rlog.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_rd%0d", lbl, i), 32'(rd_at(base + i)), 32'(ref_mem[addr + 8'(i)]));
  endtask

  initial begin
    int   base;
    wev_t e0, e1, e2;
    int   bad_m, bad_p;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state: everything low, including in_ready.
    #12;
    check("reset_outputs",
          {2'd0, bus.in_ready, bus.out_valid, bus.out_data, bus.snoopa, bus.snoopd,
           bus.snoopm, bus.snoopp, busy, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: WRMEM wrapping through 0xFF.
    base = wlog.size();
    wdata_q = '{8'h11, 8'h22, 8'h33};
    wr_burst(1'b0, 8'hFE, 1, "t1");
    e0 = ev_at(base); e1 = ev_at(base + 1); e2 = ev_at(base + 2);
    check("t1_busy_at_strobes", {29'd0, e0.busy, e1.busy, e2.busy}, 32'b110);
    check("t1_mem00", 32'(dmem[8'h00]), 32'h33);

    // 2: WRPRG back-to-back.
    base = wlog.size();
    wdata_q = '{8'hAA, 8'hBB};
    wr_burst(1'b1, 8'h10, 0, "t2");
    e0 = ev_at(base); e1 = ev_at(base + 1);
    check("t2_consecutive", 32'(e1.cyc - e0.cyc), 32'd1);
    check("t2_prg10_11", {16'd0, pmem[8'h10], pmem[8'h11]}, 32'hAABB);

    // 3: read back with host always ready.
    rd_burst(8'hFE, 3, 1'b0, "t3");

    // 4: host stalls readback for 20 cycles.
    base = rlog.size();
    bus.out_ready = 1'b0;
    send(8'hC2);
    send(8'hFE);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t4_valid_held", 32'(bus.out_valid), 32'd1);
    check("t4_data_first", 32'(bus.out_data), 32'h11);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("t4_valid_after_stall", 32'(bus.out_valid), 32'd1);
    check("t4_data_stable", 32'(bus.out_data), 32'h11);
    check("t4_no_abort", {30'd0, busy, err}, 32'b10);
    bus.out_ready = 1'b1;
    wait_idle(100);
    bus.out_ready = 1'b0;
    check("t4_count", 32'(rlog.size() - base), 32'd3);
    check("t4_bytes", {8'd0, rd_at(base), rd_at(base + 1), rd_at(base + 2)}, 32'h112233);

    // 5: watchdog abort mid-burst.
    base = wlog.size();
    send(8'h43);
    send(8'h20);
    send(8'h55);
    ref_mem[8'h20] = 8'h55;
    repeat (TIMEOUT - 2) begin
      @(posedge clk);
      #1;
    end
    check("t5_no_early_abort", {30'd0, busy, err}, 32'b10);
    wait_idle(16);
    check("t5_abort_idle", 32'(busy), 32'd0);
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_one_strobe", 32'(wlog.size() - base), 32'd1);
    e0 = ev_at(base);
    check("t5_strobe", {15'd0, e0.prg, e0.a, e0.d}, 32'h00_2055);
    send(8'h00);
    @(posedge clk);
    #1;
    check("t5_nop_stays_cmd", {30'd0, busy, err}, 32'b01);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t5_err_cleared", 32'(err), 32'd0);
    // Abort while err_clr is held: set wins.
    err_clr = 1'b1;
    send(8'h40);
    send(8'h30);
    wait_idle(TIMEOUT + 16);
    check("t5b_abort_idle", 32'(busy), 32'd0);
    check("t5b_set_wins", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    check("t5b_clear_next", 32'(err), 32'd0);
    err_clr = 1'b0;

    // 6: async reset mid-write.
    send(8'h47);
    send(8'h50);
    send(8'h01);
    send(8'h02);
    ref_mem[8'h50] = 8'h01;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          {2'd0, bus.in_ready, bus.out_valid, bus.out_data, bus.snoopa, bus.snoopd,
           bus.snoopm, bus.snoopp, busy, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_kept_50", 32'(dmem[8'h50]), 32'h01);
    check("t6_not_written_51", 32'(dmem[8'h51]), 32'(ref_mem[8'h51]));
    wdata_q = '{8'h99};
    wr_burst(1'b0, 8'h05, 0, "t6");
    check("t6_mem05", 32'(dmem[8'h05]), 32'h99);

    // Random bursts checked against the reference memories.
    for (int t = 0; t < 12; t++) begin
      int         op   = $urandom_range(0, 2);
      logic [7:0] addr = 8'($urandom_range(0, 255));
      int         n    = $urandom_range(1, 8);
      if (op < 2) begin
        wdata_q = {};
        for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom_range(0, 255)));
        wr_burst(op == 1, addr, 2, $sformatf("r%0d_wr", t));
      end else begin
        rd_burst(addr, n, 1'b1, $sformatf("r%0d_rd", t));
      end
    end

    // Final memory images and strobe exclusivity.
    bad_m = 0;
    bad_p = 0;
    for (int i = 0; i < 256; i++) begin
      if (dmem[i] !== ref_mem[i]) bad_m++;
      if (pmem[i] !== ref_prg[i]) bad_p++;
    end
    check("final_dmem_diffs", 32'(bad_m), 32'd0);
    check("final_pmem_diffs", 32'(bad_p), 32'd0);
    check("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
